// File: rtl/md_pkg.sv
// Shared encodings and constants for the multiply/divide sequencer.
package md_pkg;

    localparam int unsigned MD_W    = 32;
    localparam int unsigned MD_ITER = 32;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } md_state_e;

    // Magnitude of a two's-complement operand; unsigned operands pass through.
    function automatic logic [MD_W-1:0] md_abs(input logic [MD_W-1:0] v, input logic signed_op);
        return (signed_op && v[MD_W-1]) ? -v : v;
    endfunction

endpackage

// File: rtl/md_iter_step.sv
// One shift-add multiply or restoring divide iteration on a {hi,lo} accumulator.
module md_iter_step
    import md_pkg::*;
(
    input  logic                is_div_i,
    input  logic [2*MD_W-1:0]   acc_i,
    input  logic [MD_W-1:0]     opnd_i,
    output logic [2*MD_W-1:0]   acc_c_o
);

    logic [MD_W:0] mul_sum;
    logic [MD_W:0] div_shift;
    logic          div_ge;

    // Multiply: acc = {partial, multiplier}; divide: acc = {remainder, dividend/quotient}.
    always_comb begin
        mul_sum   = {1'b0, acc_i[2*MD_W-1:MD_W]} + (acc_i[0] ? {1'b0, opnd_i} : {(MD_W+1){1'b0}});
        div_shift = acc_i[2*MD_W-1:MD_W-1];
        div_ge    = (div_shift >= {1'b0, opnd_i});
        acc_c_o   = '0;
        if (is_div_i) begin
            acc_c_o[2*MD_W-1:MD_W] = div_ge ? MD_W'(div_shift - {1'b0, opnd_i}) : div_shift[MD_W-1:0];
            acc_c_o[MD_W-1:0]      = {acc_i[MD_W-2:0], div_ge};
        end else begin
            acc_c_o = {mul_sum, acc_i[MD_W-1:1]};
        end
    end

endmodule

// File: rtl/md_sequencer.sv
// Multi-cycle mult/div sequencer owning HI/LO, with mthi/mtlo and pipeline stall.
// Define MD_FAST_MUL_EN for single-cycle mult/multu (divide stays iterative).
module md_sequencer
    import md_pkg::*;
#(
    parameter int unsigned ITER = MD_ITER
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic [1:0]      op_i,
    input  logic [MD_W-1:0] opa_i,
    input  logic [MD_W-1:0] opb_i,
    input  logic            mthi_en_i,
    input  logic            mtlo_en_i,
    input  logic [MD_W-1:0] wdata_i,
    input  logic            rd_req_i,
    input  logic            abort_i,
    output logic            busy_o,
    output logic            stall_c_o,
    output logic            done_o,
    output logic            div_zero_o,
    output logic [MD_W-1:0] hi_o,
    output logic [MD_W-1:0] lo_o
);

    localparam int unsigned CW = (ITER > 1) ? $clog2(ITER) : 1;
    localparam int unsigned AW = 2 * MD_W;

    md_state_e       state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   acc_q, acc_d, acc_step, mul_fast, prod_fix;
    logic [MD_W-1:0] opnd_q, opnd_d, hi_q, hi_d, lo_q, lo_d;
    logic [MD_W-1:0] a_mag, b_mag, quo_fix, rem_fix;
    logic            is_div_q, is_div_d, neg_q, neg_d, neg_rem_q, neg_rem_d, dz_q, dz_d;
    logic            busy_q, busy_d, done_q, done_d, div_zero_q, div_zero_d;
    logic            op_div, is_signed, opb_zero, accept, short_path;
    md_op_e          op;

    assign op        = md_op_e'(op_i);
    assign op_div    = (op == MD_DIV) || (op == MD_DIVU);
    assign is_signed = (op == MD_MULT) || (op == MD_DIV);
    assign opb_zero  = (opb_i == '0);
    assign a_mag     = md_abs(opa_i, is_signed);
    assign b_mag     = md_abs(opb_i, is_signed);
    assign accept    = start_i && !abort_i && (state_q == ST_IDLE);

`ifdef MD_FAST_MUL_EN
    assign short_path = op_div ? opb_zero : 1'b1;
    assign mul_fast   = AW'(a_mag) * AW'(b_mag);
`else
    assign short_path = op_div && opb_zero;
    assign mul_fast   = '0;
`endif

    md_iter_step u_step (
        .is_div_i (is_div_q),
        .acc_i    (acc_q),
        .opnd_i   (opnd_q),
        .acc_c_o  (acc_step)
    );

    assign prod_fix = neg_q ? -acc_q : acc_q;
    assign quo_fix  = neg_q ? -acc_q[MD_W-1:0] : acc_q[MD_W-1:0];
    assign rem_fix  = neg_rem_q ? -acc_q[AW-1:MD_W] : acc_q[AW-1:MD_W];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // Abort overrides every transition, including a simultaneous start or completion.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = short_path ? ST_FIX : ST_RUN;
            ST_RUN:  if (cnt_q == CW'(ITER - 1)) state_d = ST_FIX;
            ST_FIX:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (abort_i) state_d = ST_IDLE;
    end

    always_comb begin
        acc_d      = acc_q;
        opnd_d     = opnd_q;
        is_div_d   = is_div_q;
        neg_d      = neg_q;
        neg_rem_d  = neg_rem_q;
        dz_d       = dz_q;
        cnt_d      = cnt_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        div_zero_d = div_zero_q;
        done_d     = 1'b0;
        busy_d     = (state_d != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (mthi_en_i) hi_d = wdata_i;
                if (mtlo_en_i) lo_d = wdata_i;
                if (accept) begin
                    cnt_d      = '0;
                    is_div_d   = op_div;
                    neg_d      = is_signed && (opa_i[MD_W-1] ^ opb_i[MD_W-1]);
                    neg_rem_d  = is_signed && opa_i[MD_W-1];
                    dz_d       = op_div && opb_zero;
                    div_zero_d = 1'b0;
                    if (op_div && opb_zero) begin
                        acc_d = {opa_i, {MD_W{1'b1}}};
                    end else if (short_path) begin
                        acc_d = mul_fast;
                    end else if (op_div) begin
                        acc_d  = {{MD_W{1'b0}}, a_mag};
                        opnd_d = b_mag;
                    end else begin
                        acc_d  = {{MD_W{1'b0}}, b_mag};
                        opnd_d = a_mag;
                    end
                end
            end
            ST_RUN: begin
                acc_d = acc_step;
                cnt_d = cnt_q + 1'b1;
            end
            ST_FIX: begin
                if (!abort_i) begin
                    done_d     = 1'b1;
                    div_zero_d = dz_q;
                    if (dz_q)          {hi_d, lo_d} = acc_q;
                    else if (is_div_q) {hi_d, lo_d} = {rem_fix, quo_fix};
                    else               {hi_d, lo_d} = prod_fix;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q      <= '0;
            opnd_q     <= '0;
            is_div_q   <= 1'b0;
            neg_q      <= 1'b0;
            neg_rem_q  <= 1'b0;
            dz_q       <= 1'b0;
            cnt_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            div_zero_q <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            opnd_q     <= opnd_d;
            is_div_q   <= is_div_d;
            neg_q      <= neg_d;
            neg_rem_q  <= neg_rem_d;
            dz_q       <= dz_d;
            cnt_q      <= cnt_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            div_zero_q <= div_zero_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign div_zero_o = div_zero_q;
    assign hi_o       = hi_q;
    assign lo_o       = lo_q;
    assign stall_c_o  = busy_q && (start_i || rd_req_i || mthi_en_i || mtlo_en_i);

endmodule

// File: tb/tb_md_sequencer.sv
// Randomized bench for md_sequencer against an arithmetic reference of HI/LO behaviour.
module tb_md_sequencer;
    import md_pkg::*;

`ifdef MD_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, mthi_en, mtlo_en, rd_req, abort;
    logic [1:0]  op;
    logic [31:0] opa, opb, wdata;
    logic        busy, stall, done, div_zero;
    logic [31:0] hi, lo;

    always #5 clk = ~clk;

    md_sequencer dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .start_i    (start),
        .op_i       (op),
        .opa_i      (opa),
        .opb_i      (opb),
        .mthi_en_i  (mthi_en),
        .mtlo_en_i  (mtlo_en),
        .wdata_i    (wdata),
        .rd_req_i   (rd_req),
        .abort_i    (abort),
        .busy_o     (busy),
        .stall_c_o  (stall),
        .done_o     (done),
        .div_zero_o (div_zero),
        .hi_o       (hi),
        .lo_o       (lo)
    );

    int n_vec = 0;
    int n_err = 0;
    int stall_seen = 0;

    // Reference state: architectural HI/LO plus a countdown to the pending result.
    logic        m_busy, m_done, m_dz, m_dzp;
    logic [31:0] m_hi, m_lo;
    logic [63:0] m_res;
    int          m_rem;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Result as {HI,LO} straight from the arithmetic definition of each op.
    task automatic ref_calc(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                            output logic [63:0] res, output logic dz, output int lat);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [31:0]     q, r;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'h0, a};
        ub  = {32'h0, b};
        dz  = 1'b0;
        lat = 33;
        res = '0;
        q   = '0;
        r   = '0;
        if (o == 2'b00 || o == 2'b01) begin
            lat = MUL_LAT;
            res = (o == 2'b00) ? 64'(sa * sb) : 64'(ua * ub);
        end else if (b == 32'h0) begin
            dz  = 1'b1;
            lat = 1;
            res = {a, 32'hFFFF_FFFF};
        end else if (o == 2'b10) begin
            q   = 32'(sa / sb);
            r   = 32'(sa % sb);
            res = {r, q};
        end else begin
            q   = 32'(ua / ub);
            r   = 32'(ua % ub);
            res = {r, q};
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b0; m_done = 1'b0; m_dz = 1'b0; m_dzp = 1'b0;
        m_hi = '0; m_lo = '0; m_res = '0; m_rem = 0;
    endtask

    task automatic model_step();
        m_done = 1'b0;
        if (m_busy) begin
            if (abort) begin
                m_busy = 1'b0;
            end else begin
                m_rem--;
                if (m_rem == 0) begin
                    {m_hi, m_lo} = m_res;
                    m_dz   = m_dzp;
                    m_busy = 1'b0;
                    m_done = 1'b1;
                end
            end
        end else begin
            if (mthi_en) m_hi = wdata;
            if (mtlo_en) m_lo = wdata;
            if (start && !abort) begin
                ref_calc(op, opa, opb, m_res, m_dzp, m_rem);
                m_busy = 1'b1;
                m_dz   = 1'b0;
            end
        end
    endtask

    // One clock: check stall against current inputs, step the model, then check registers.
    task automatic tick();
        #1;
        chk("stall", 64'(stall), 64'(m_busy & (start | rd_req | mthi_en | mtlo_en)));
        if (stall) stall_seen++;
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("busy", 64'(busy), 64'(m_busy));
        chk("done", 64'(done), 64'(m_done));
        chk("div_zero", 64'(div_zero), 64'(m_dz));
        chk("hi", 64'(hi), 64'(m_hi));
        chk("lo", 64'(lo), 64'(m_lo));
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, output int lat);
        op = o; opa = a; opb = b; start = 1'b1;
        tick();
        start = 1'b0;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!done && lat < 100);
        if (!done) chk("done_timeout", 64'(done), 64'(1));
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            5:       return 32'($urandom_range(0, 15));
            default: return $urandom();
        endcase
    endfunction

    initial begin
        int lat;
        rst_n = 1'b0; start = 1'b0; op = 2'b00; opa = '0; opb = '0;
        mthi_en = 1'b0; mtlo_en = 1'b0; wdata = '0; rd_req = 1'b0; abort = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_hi", 64'(hi), 64'(0));
        chk("rst_lo", 64'(lo), 64'(0));
        rst_n = 1'b1;

        run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
        chk("multu_lat", 64'(lat), 64'(MUL_LAT));
        chk("multu_hi", 64'(hi), 64'h0000_0000_FFFF_FFFE);
        chk("multu_lo", 64'(lo), 64'h0000_0000_0000_0001);

        run_op(MD_MULT, 32'hFFFF_FFFD, 32'd7, lat);
        chk("mult_hi", 64'(hi), 64'h0000_0000_FFFF_FFFF);
        chk("mult_lo", 64'(lo), 64'h0000_0000_FFFF_FFEB);

        run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, lat);
        chk("div_lat", 64'(lat), 64'(33));
        chk("div_hi", 64'(hi), 64'h0000_0000_FFFF_FFFF);
        chk("div_lo", 64'(lo), 64'h0000_0000_FFFF_FFFD);

        run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat);
        chk("ovf_hi", 64'(hi), 64'h0);
        chk("ovf_lo", 64'(lo), 64'h0000_0000_8000_0000);

        run_op(MD_DIVU, 32'd7, 32'd0, lat);
        chk("dz_lat", 64'(lat), 64'(1));
        chk("dz_hi", 64'(hi), 64'h7);
        chk("dz_lo", 64'(lo), 64'h0000_0000_FFFF_FFFF);
        chk("dz_flag", 64'(div_zero), 64'(1));

        // mtlo and mfhi held across a whole operation
        rd_req = 1'b1; mtlo_en = 1'b1; wdata = 32'h1234_5678;
        stall_seen = 0;
        run_op(MD_MULTU, 32'd5, 32'd6, lat);
        chk("hold_stall_cnt", 64'(stall_seen), 64'(MUL_LAT));
        chk("hold_res_lo", 64'(lo), 64'd30);
        chk("hold_dz_clr", 64'(div_zero), 64'(0));
        tick();
        chk("hold_mtlo_lo", 64'(lo), 64'h1234_5678);
        chk("hold_mtlo_hi", 64'(hi), 64'h0);
        rd_req = 1'b0; mtlo_en = 1'b0;

        // abort while the counter sits at 10
        op = MD_DIVU; opa = 32'd100; opb = 32'd7; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_hi", 64'(hi), 64'h0);
        chk("abort_lo", 64'(lo), 64'h1234_5678);
        repeat (30) tick();
        run_op(MD_DIVU, 32'd100, 32'd7, lat);
        chk("post_abort_lo", 64'(lo), 64'd14);
        chk("post_abort_hi", 64'(hi), 64'd2);

        // asynchronous reset in the middle of an iteration
        op = MD_DIV; opa = 32'd1000; opb = 32'd3; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (12) tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 64'(busy), 64'(0));
        chk("mid_rst_done", 64'(done), 64'(0));
        chk("mid_rst_hi", 64'(hi), 64'h0);
        chk("mid_rst_lo", 64'(lo), 64'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        run_op(MD_MULTU, 32'd2, 32'd3, lat);
        chk("after_rst_lo", 64'(lo), 64'd6);

        for (int i = 0; i < 4000; i++) begin
            start   = ($urandom_range(0, 3) == 0);
            op      = 2'($urandom_range(0, 3));
            opa     = pick();
            opb     = pick();
            mthi_en = ($urandom_range(0, 15) == 0);
            mtlo_en = ($urandom_range(0, 15) == 0);
            wdata   = $urandom();
            rd_req  = ($urandom_range(0, 7) == 0);
            abort   = ($urandom_range(0, 63) == 0);
            tick();
        end
        start = 1'b0; mthi_en = 1'b0; mtlo_en = 1'b0; rd_req = 1'b0; abort = 1'b0;
        repeat (40) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/md_sequencer.md
# md_sequencer

Multi-cycle multiply/divide sequencer that owns the architectural HI/LO registers of the CPU. It accepts mult/multu/div/divu issued from the execute stage, runs a 32-iteration shift-add multiply or restoring divide, and writes HI/LO on completion. It also serves mthi/mtlo writes and raises a pipeline stall whenever HI/LO are read or written, or a new operation is started, while an operation is in flight.

## Interface
Parameters:
- ITER, 32, iteration count; equals operand width, fixed at 32 for this CPU.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  one clock; reset is asynchronous and active-low.
- start  in  1  issue request, sampled each edge.
- op  in  2  00 mult, 01 multu, 10 div, 11 divu (= Function_opcode[1:0]).
- opa  in  32  rs value (multiplicand / dividend).
- opb  in  32  rt value (multiplier / divisor).
- mthi_en  in  1  write wdata to HI.
- mtlo_en  in  1  write wdata to LO.
- wdata  in  32  mthi/mtlo data.
- rd_req  in  1  mfhi/mflo in execute stage.
- abort  in  1  flush; cancels the operation in flight.
- busy  out  1  operation in flight.
- stall  out  1  = busy & (start | rd_req | mthi_en | mtlo_en).
- done  out  1  one-cycle completion pulse.
- div_zero  out  1  last divide had opb==0; cleared at the next accepted start.
- hi  out  32  HI register.
- lo  out  32  LO register.

## Operation
- States: IDLE, RUN, FIX.
- IDLE + start (no abort):
  - Capture |opa| and |opb| for signed ops (raw values for unsigned).
  - Record result signs: product sign = a^b; quotient sign = a^b; remainder sign = a.
  - Clear count. Next state is RUN; for div/divu with opb==0, next state is FIX directly.
- RUN: one iteration per cycle.
  - Multiply: 64-bit accumulator, add-and-shift on multiplier LSB.
  - Divide: restoring step; shift remainder left, trial-subtract divisor, set quotient bit.
  - At count==ITER-1, next state is FIX.
- FIX: apply sign fixup (two's-complement negate where the recorded sign is set).
  - Write {HI,LO} = 64-bit product, or HI = remainder, LO = quotient.
  - Go to IDLE and assert done for the following cycle.
- Divide by zero: HI = opa (raw), LO = 32'hFFFF_FFFF, div_zero=1; no sign fixup applied.
- Signed overflow: 0x8000_0000 / -1 gives LO=0x8000_0000, HI=0, falling out of the magnitude method.
- mthi/mtlo: apply only when not busy; otherwise they are held off by stall. If they coincide with an accepted start, the write applies now and the result overwrites it at FIX.
- start while busy: ignored; stall asserted.
- abort: any state goes to IDLE at the next edge; HI/LO and div_zero unchanged; no done. Abort wins over a simultaneous start or completion.
- Reset: state IDLE, count=0, hi=lo=0, busy=0, done=0, div_zero=0.

## Timing
- start accepted at edge E0; busy high from E0 until E33.
- Iterations occur on E1..E32; HI/LO written at E33; done high in the cycle after E33. Total latency is 33 edges.
- Divide by zero (and fast multiply, see Configuration): FIX entered at E0, HI/LO written at E1, done after E1.
- busy and done are registered; stall is combinational from busy.
- Back-to-back: start is accepted in the same cycle done is high (state IDLE).

## Configuration
- MD_FAST_MUL_EN defined: mult/multu compute a single-cycle 32x32 signed/unsigned product at E0 and go straight to FIX (latency 1). Divide is unchanged.
- Undefined: all ops are iterative, with the latencies above.

## Structure
- Package md_pkg holds: op encodings (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU), state enum, ITER constant.
- Sub-module md_iter_step: combinational single iteration (mul add-shift / div restore) selected by an is_div input.
- The FSM, counter and HI/LO registers stay in md_sequencer.

## Test plan
- multu 0xFFFF_FFFF × 0xFFFF_FFFF -> HI=0xFFFF_FFFE, LO=0x0000_0001, done exactly 33 edges after start.
- mult -3 × 7 -> HI=0xFFFF_FFFF, LO=0xFFFF_FFEB; div -7/2 -> LO=0xFFFF_FFFD, HI=0xFFFF_FFFF.
- div 0x8000_0000 / 0xFFFF_FFFF -> LO=0x8000_0000, HI=0; divu 7/0 -> HI=7, LO=0xFFFF_FFFF, div_zero=1, done one edge after start.
- rd_req and mtlo_en held during an op -> stall=1 every busy cycle, LO takes wdata only after busy drops, and the mtlo write follows the result.
- abort at count=10 -> busy=0 next cycle, HI/LO keep prior values, no done pulse; then a new start runs normally.
- reset asserted mid-RUN -> immediately busy=0, hi=lo=0, done=0. After release, multu 2×3 -> LO=6.
